mc_control: RTL and testbench

- Multi-cycle main controller for the CPU datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath muxes, memory strobes and register-file write enable.
- Sits directly upstream of the ALU and supplies its 3-bit alu_func: 001 add, 010 sub, 011 and, 100 or, 101 slt, 000 zero.

---
 rtl/mc_pkg.sv | 83 ++++++++
 rtl/mc_if.sv | 42 ++++
 rtl/mc_alu_decoder.sv | 26 ++
 rtl/mc_control.sv | 157 +++++++++++++++
 tb/tb_mc_control.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mc_pkg.sv
// mc_pkg: shared constants for the multi-cycle main controller.
//   - instruction opcode / funct field values
//   - ALU operation codes driven on alu_func
//   - ALU-B operand and PC-source mux encodings
//   - 4-bit FSM state encodings (S_IDLE = 0)
//   - control-output bundle type and a retire-state helper
package mc_pkg;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU operation codes
    localparam logic [2:0] ALU_ZERO = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_SUB  = 3'b010;
    localparam logic [2:0] ALU_AND  = 3'b011;
    localparam logic [2:0] ALU_OR   = 3'b100;
    localparam logic [2:0] ALU_SLT  = 3'b101;

    // ALU B-operand select
    localparam logic [1:0] ALUB_REG    = 2'b00;
    localparam logic [1:0] ALUB_FOUR   = 2'b01;
    localparam logic [1:0] ALUB_IMM    = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // FSM state encodings
    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_FETCH    = 4'd1;
    localparam logic [3:0] S_DECODE   = 4'd2;
    localparam logic [3:0] S_MEM_ADDR = 4'd3;
    localparam logic [3:0] S_MEM_RD   = 4'd4;
    localparam logic [3:0] S_MEM_WB   = 4'd5;
    localparam logic [3:0] S_MEM_WR   = 4'd6;
    localparam logic [3:0] S_EXEC_R   = 4'd7;
    localparam logic [3:0] S_R_WB     = 4'd8;
    localparam logic [3:0] S_EXEC_I   = 4'd9;
    localparam logic [3:0] S_I_WB     = 4'd10;
    localparam logic [3:0] S_BRANCH   = 4'd11;
    localparam logic [3:0] S_JUMP     = 4'd12;
    localparam logic [3:0] S_ILLEGAL  = 4'd13;

    // Datapath control bundle decoded from the current state
    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_func;
        logic       illegal_op;
    } ctrl_t;

    // States that always complete an instruction when they are left.
    // S_MEM_WR retires only on its mem_ready cycle, so it is handled apart.
    function automatic logic retires_unconditionally(logic [3:0] st);
        return (st == S_MEM_WB) || (st == S_R_WB) || (st == S_I_WB) ||
               (st == S_BRANCH) || (st == S_JUMP);
    endfunction

endpackage

// File: rtl/mc_if.sv
// mc_if: controller <-> datapath bundle.
//   master (controller): samples opcode/funct/zero/mem_ready, drives all
//                        mux selects, strobes, status pulses, counter, state.
//   slave  (datapath):   the mirror image.
interface mc_if #(
    parameter int CNT_W = 32
);
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic             zero;
    logic             mem_ready;
    logic             pc_write;
    logic             i_or_d;
    logic             mem_read;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic             alu_src_a;
    logic [1:0]       alu_src_b;
    logic [1:0]       pc_source;
    logic [2:0]       alu_func;
    logic             illegal_op;
    logic             retired;
    logic [CNT_W-1:0] instr_count;
    logic [3:0]       state_dbg;

    modport master (
        input  opcode, funct, zero, mem_ready,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_func, illegal_op, retired, instr_count, state_dbg
    );

    modport slave (
        output opcode, funct, zero, mem_ready,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, reg_dst,
               mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_source,
               alu_func, illegal_op, retired, instr_count, state_dbg
    );
endinterface

// File: rtl/mc_alu_decoder.sv
// mc_alu_decoder: combinational R-type funct decoder.
//   funct_i       in  6  instr[5:0]
//   alu_func_o    out 3  ALU operation for this funct (000 when unsupported)
//   funct_valid_o out 1  funct is one of the supported R-type operations
module mc_alu_decoder
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_func_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_func_o    = ALU_ZERO;
        funct_valid_o = 1'b1;
        case (funct_i)
            FN_ADD:  alu_func_o = ALU_ADD;
            FN_SUB:  alu_func_o = ALU_SUB;
            FN_AND:  alu_func_o = ALU_AND;
            FN_OR:   alu_func_o = ALU_OR;
            FN_SLT:  alu_func_o = ALU_SLT;
            default: funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multi-cycle main controller for the CPU datapath.
//   clk  in  system clock, rising edge
//   rst  in  synchronous active-high reset (overrides every input)
//   ctl  mc_if.master: opcode/funct/zero/mem_ready in; mux selects, memory
//        strobes, register write enable, alu_func, illegal_op, retired,
//        instr_count and state_dbg out.
// Outputs are decoded from the state alone, except pc_write/ir_write in
// S_FETCH (follow mem_ready), pc_write in S_BRANCH (follows zero) and
// retired in S_MEM_WR (follows mem_ready).
module mc_control
    import mc_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic clk,
    input  logic rst,
    mc_if.master ctl
);

    logic [3:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    ctrl_t            ctrl;
    logic             retire;
    logic [2:0]       dec_alu_func;
    logic             dec_funct_valid;

    mc_alu_decoder u_alu_dec (
        .funct_i       (ctl.funct),
        .alu_func_o    (dec_alu_func),
        .funct_valid_o (dec_funct_valid)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (ctl.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (ctl.opcode)
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_RTYPE:     state_d = dec_funct_valid ? S_EXEC_R : S_ILLEGAL;
                    OP_ADDI:      state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            // The IR is only loaded in S_FETCH, so opcode is still the
            // current instruction here.
            S_MEM_ADDR: state_d = (ctl.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (ctl.mem_ready) state_d = S_MEM_WB;
            S_MEM_WR:   if (ctl.mem_ready) state_d = S_FETCH;
            S_EXEC_R:   state_d = S_R_WB;
            S_EXEC_I:   state_d = S_I_WB;
            S_MEM_WB, S_R_WB, S_I_WB, S_BRANCH, S_JUMP, S_ILLEGAL:
                        state_d = S_FETCH;
            // Unused encodings fall back to a clean restart.
            default:    state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        ctrl = '0;
        case (state_q)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = ALUB_FOUR;
                ctrl.alu_func  = ALU_ADD;
                ctrl.pc_source = PCSRC_ALU;
                ctrl.ir_write  = ctl.mem_ready;
                ctrl.pc_write  = ctl.mem_ready;
            end
            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                ctrl.alu_src_b = ALUB_IMM_SH;
                ctrl.alu_func  = ALU_ADD;
            end
            S_MEM_ADDR, S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_IMM;
                ctrl.alu_func  = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEM_WB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_write = 1'b1;
                ctrl.i_or_d    = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_func  = dec_alu_func;
            end
            S_R_WB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_I_WB: ctrl.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = ALUB_REG;
                ctrl.alu_func  = ALU_SUB;
                ctrl.pc_source = PCSRC_ALUOUT;
                ctrl.pc_write  = ctl.zero;
            end
            S_JUMP: begin
                ctrl.pc_source = PCSRC_JUMP;
                ctrl.pc_write  = 1'b1;
            end
            S_ILLEGAL: ctrl.illegal_op = 1'b1;
            default: ;
        endcase
    end

    // A reset in the same cycle as a retire suppresses the retire pulse.
    assign retire = !rst && (retires_unconditionally(state_q) ||
                             (state_q == S_MEM_WR && ctl.mem_ready));

    // Free-running count, wraps from all-ones to zero.
    assign count_d = retire ? count_q + CNT_W'(1) : count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign ctl.pc_write    = ctrl.pc_write;
    assign ctl.i_or_d      = ctrl.i_or_d;
    assign ctl.mem_read    = ctrl.mem_read;
    assign ctl.mem_write   = ctrl.mem_write;
    assign ctl.ir_write    = ctrl.ir_write;
    assign ctl.reg_dst     = ctrl.reg_dst;
    assign ctl.mem_to_reg  = ctrl.mem_to_reg;
    assign ctl.reg_write   = ctrl.reg_write;
    assign ctl.alu_src_a   = ctrl.alu_src_a;
    assign ctl.alu_src_b   = ctrl.alu_src_b;
    assign ctl.pc_source   = ctrl.pc_source;
    assign ctl.alu_func    = ctrl.alu_func;
    assign ctl.illegal_op  = ctrl.illegal_op;
    assign ctl.retired     = retire;
    assign ctl.instr_count = count_q;
    assign ctl.state_dbg   = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: table-driven check of mc_control. Each table row is one
// instruction with its expected state path written as hex state digits;
// every cycle an expected record is queued and compared against the DUT.
module tb_mc_control;

    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mc_if #(.CNT_W(CW)) ifc ();

    mc_control #(.CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .ctl (ifc)
    );

    typedef struct packed {
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [2:0] alu_func;
        logic       illegal_op;
        logic       retired;
    } ctl_t;

    typedef struct {
        logic [3:0]    st;
        ctl_t          ctl;
        logic [CW-1:0] cnt;
        string         tag;
    } exp_t;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] fn;
        logic       z;
        string      path;   // hex state digits, one per cycle
        logic [2:0] fx;     // alu_func expected in EXEC_R
        bit         ret;
        int         rst_at; // cycle index where rst is raised, -1 none
    } vec_t;

    ctl_t          dut_ctl;
    exp_t          exp_q[$];
    vec_t          tbl[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic [CW-1:0] cnt_m;

    always_comb begin
        dut_ctl.pc_write   = ifc.pc_write;
        dut_ctl.i_or_d     = ifc.i_or_d;
        dut_ctl.mem_read   = ifc.mem_read;
        dut_ctl.mem_write  = ifc.mem_write;
        dut_ctl.ir_write   = ifc.ir_write;
        dut_ctl.reg_dst    = ifc.reg_dst;
        dut_ctl.mem_to_reg = ifc.mem_to_reg;
        dut_ctl.reg_write  = ifc.reg_write;
        dut_ctl.alu_src_a  = ifc.alu_src_a;
        dut_ctl.alu_src_b  = ifc.alu_src_b;
        dut_ctl.pc_source  = ifc.pc_source;
        dut_ctl.alu_func   = ifc.alu_func;
        dut_ctl.illegal_op = ifc.illegal_op;
        dut_ctl.retired    = ifc.retired;
    end

    function automatic logic [3:0] nib(string s, int i);
        byte c;
        c = s[i];
        if (c >= "a") return 4'(c - "a" + 10);
        return 4'(c - "0");
    endfunction

    // Expected outputs per state (1 FETCH .. d ILLEGAL).
    function automatic ctl_t model(logic [3:0] st, logic [2:0] fx, logic mr,
                                   logic z, logic ret);
        ctl_t c;
        c = '0;
        case (st)
            4'h1: begin c.mem_read = 1; c.alu_src_b = 2'b01; c.alu_func = 3'b001;
                        c.ir_write = mr; c.pc_write = mr; end
            4'h2: begin c.alu_src_b = 2'b11; c.alu_func = 3'b001; end
            4'h3: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_func = 3'b001; end
            4'h4: begin c.mem_read = 1; c.i_or_d = 1; end
            4'h5: begin c.reg_write = 1; c.mem_to_reg = 1; end
            4'h6: begin c.mem_write = 1; c.i_or_d = 1; end
            4'h7: begin c.alu_src_a = 1; c.alu_src_b = 2'b00; c.alu_func = fx; end
            4'h8: begin c.reg_write = 1; c.reg_dst = 1; end
            4'h9: begin c.alu_src_a = 1; c.alu_src_b = 2'b10; c.alu_func = 3'b001; end
            4'ha: begin c.reg_write = 1; end
            4'hb: begin c.alu_src_a = 1; c.alu_func = 3'b010; c.pc_source = 2'b01;
                        c.pc_write = z; end
            4'hc: begin c.pc_source = 2'b10; c.pc_write = 1; end
            4'hd: begin c.illegal_op = 1; end
            default: ;
        endcase
        c.retired = ret;
        return c;
    endfunction

    // Queue the expectation for the current cycle, compare at the falling
    // edge, then return 1 time unit after the next rising edge.
    task automatic step(logic [3:0] st, ctl_t c, string tag);
        exp_t e;
        e.st  = st;
        e.ctl = c;
        e.cnt = cnt_m;
        e.tag = tag;
        exp_q.push_back(e);
        @(negedge clk);
        e = exp_q.pop_front();
        n_cmp++;
        if (ifc.state_dbg !== e.st || dut_ctl !== e.ctl || ifc.instr_count !== e.cnt) begin
            n_bad++;
            $display("FAIL %s: state/ctl/count got %h/%h/%h required %h/%h/%h",
                     e.tag, ifc.state_dbg, dut_ctl, ifc.instr_count, e.st, e.ctl, e.cnt);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(logic [CW-1:0] req, string tag);
        n_cmp++;
        if (ifc.instr_count !== req) begin
            n_bad++;
            $display("FAIL %s: instr_count got %0d required %0d", tag, ifc.instr_count, req);
        end
    endtask

    task automatic add_vec(string name, logic [5:0] op, logic [5:0] fn, logic z,
                           string path, logic [2:0] fx, bit ret, int rst_at);
        vec_t v;
        v.name = name; v.op = op; v.fn = fn; v.z = z; v.path = path;
        v.fx = fx; v.ret = ret; v.rst_at = rst_at;
        tbl.push_back(v);
    endtask

    task automatic run_vec(vec_t v);
        int         len;
        logic [3:0] st, nx;
        logic       mr, ret;
        len = v.path.len();
        ifc.opcode = v.op;
        ifc.funct  = v.fn;
        ifc.zero   = v.z;
        for (int i = 0; i < len; i++) begin
            st = nib(v.path, i);
            nx = (i + 1 < len) ? nib(v.path, i + 1) : 4'h1;
            if (st == 4'h1 || st == 4'h4 || st == 4'h6)
                mr = !(st == nx);          // a repeated state is a stall cycle
            else
                mr = 1'($urandom_range(0, 1)); // mem_ready is a don't-care here
            ret = v.ret && (i == len - 1);
            if (i == v.rst_at) begin
                rst = 1'b1;
                mr  = 1'b0;
                ret = 1'b0;
            end
            ifc.mem_ready = mr;
            step(st, model(st, v.fx, mr, v.z, ret), v.name);
            if (i == v.rst_at) begin
                rst   = 1'b0;
                cnt_m = '0;
                ifc.mem_ready = 1'b1;
                step(4'h0, '0, {v.name, "_after_rst"});
                $display("instr %s op=%h fn=%h reset at cycle %0d count=%0d",
                         v.name, v.op, v.fn, i, cnt_m);
                return;
            end
            if (ret) cnt_m++;
        end
        $display("instr %s op=%h fn=%h cycles=%0d count=%0d",
                 v.name, v.op, v.fn, len, cnt_m);
    endtask

    vec_t jv;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "timeout");
    end

    initial begin
        //       name        op     fn     z  path        fx      ret rst_at
        add_vec("add",       6'h00, 6'h20, 0, "1278",     3'b001, 1, -1);
        add_vec("slt",       6'h00, 6'h2A, 0, "1278",     3'b101, 1, -1);
        add_vec("lw_stall3", 6'h23, 6'h00, 0, "12344445", 3'b000, 1, -1);
        add_vec("sw_stall1", 6'h2B, 6'h00, 0, "12366",    3'b000, 1, -1);
        add_vec("beq_z1",    6'h04, 6'h00, 1, "12b",      3'b000, 1, -1);
        add_vec("beq_z0",    6'h04, 6'h00, 0, "12b",      3'b000, 1, -1);
        add_vec("addi",      6'h08, 6'h11, 0, "129a",     3'b000, 1, -1);
        add_vec("j",         6'h02, 6'h00, 0, "12c",      3'b000, 1, -1);
        add_vec("ill_op3f",  6'h3F, 6'h20, 0, "12d",      3'b000, 0, -1);
        add_vec("ill_fn27",  6'h00, 6'h27, 0, "12d",      3'b000, 0, -1);
        add_vec("sub",       6'h00, 6'h22, 0, "1278",     3'b010, 1, -1);
        add_vec("and",       6'h00, 6'h24, 1, "1278",     3'b011, 1, -1);
        add_vec("or_fstall", 6'h00, 6'h25, 0, "11278",    3'b100, 1, -1);
        add_vec("rst_in_j",  6'h02, 6'h00, 0, "12c",      3'b000, 1,  2);
        add_vec("rst_in_sw", 6'h2B, 6'h00, 0, "1236",     3'b000, 1,  3);

        rst           = 1'b1;
        ifc.opcode    = '0;
        ifc.funct     = '0;
        ifc.zero      = 1'b0;
        ifc.mem_ready = 1'b1;   // reset must win over mem_ready
        cnt_m         = '0;

        @(posedge clk);
        #1;
        step(4'h0, '0, "reset_hold");
        rst = 1'b0;
        step(4'h0, '0, "reset_idle");

        foreach (tbl[k]) run_vec(tbl[k]);

        // Counter wrap: count is 0 after the reset rows above.
        jv.name = "j_wrap"; jv.op = 6'h02; jv.fn = 6'h00; jv.z = 1'b0;
        jv.path = "12c"; jv.fx = 3'b000; jv.ret = 1'b1; jv.rst_at = -1;
        repeat (15) run_vec(jv);
        check_cnt(CW'(15), "count_before_wrap");
        run_vec(jv);
        check_cnt(CW'(0), "count_after_wrap");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
